// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receiver.
// Holds FSM encoding, frame constants and a parity helper.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_state_e;

   localparam int PS2_FRAME_BITS = 11;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   // Odd parity holds when data plus parity has an odd count of ones.
   function automatic logic odd_ok(
      input logic [7:0] d,
      input logic       p
   );
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: synchronous FIFO for received bytes.
// Ports: clk, reset_n, push/wdata in, pop in, head/empty/full out.
// A pop on empty is ignored; a push on full needs a same-cycle pop.
module ps2_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

   // Full push is allowed only when a pop frees the slot.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver with byte FIFO.
// Ports: clk, reset_n, ps2_clk, ps2_dat, ps2_read, err_clr in;
//        keycode, key_avail, frame_err, overflow out.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   input  logic       ps2_read,
   input  logic       err_clr,
   output logic [7:0] keycode,
   output logic       key_avail,
   output logic       frame_err,
   output logic       overflow
);

   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

   logic           clk_s1, clk_s2, clk_s3;
   logic           dat_s1, dat_s2;
   logic           fall;
   logic           rd_q;
   logic           pop_q;
   ps2_state_e     state;
   logic [2:0]     bit_cnt;
   logic [7:0]     shreg;
   logic           par_bit;
   logic [WDW-1:0] wdog;
   logic           push;
   logic           empty;
   logic           full;

   // Synchronisers idle high so reset never fakes an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= ps2_dat;
         dat_s2 <= dat_s1;
      end
   end

   assign fall = clk_s3 & ~clk_s2;

   // Registered pop strobe: one pop per ps2_read rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q  <= 1'b0;
         pop_q <= 1'b0;
      end else begin
         rd_q  <= ps2_read;
         pop_q <= ps2_read & ~rd_q;
      end
   end

   assign push = fall && (state == ST_STOP) && dat_s2
              && odd_ok(shreg, par_bit);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         wdog      <= '0;
         frame_err <= 1'b0;
      end else begin
         // Clear first so a same-cycle error set overrides it.
         if (err_clr)
            frame_err <= 1'b0;
         if (fall) begin
            wdog <= '0;
            unique case (state)
               ST_IDLE: begin
                  if (!dat_s2) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               ST_DATA: begin
                  shreg <= {dat_s2, shreg[7:1]};
                  if (bit_cnt == 3'd7)
                     state <= ST_PARITY;
                  else
                     bit_cnt <= bit_cnt + 3'd1;
               end
               ST_PARITY: begin
                  par_bit <= dat_s2;
                  state   <= ST_STOP;
               end
               ST_STOP: begin
                  if (!(dat_s2 && odd_ok(shreg, par_bit)))
                     frame_err <= 1'b1;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE) begin
            // Watchdog aborts a frame whose clock stalled.
            if (wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
               state     <= ST_IDLE;
               wdog      <= '0;
               frame_err <= 1'b1;
            end else begin
               wdog <= wdog + WDW'(1);
            end
         end else begin
            wdog <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else begin
         if (err_clr)
            overflow <= 1'b0;
         if (push && full && !pop_q)
            overflow <= 1'b1;
      end
   end

   ps2_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (shreg),
      .pop     (pop_q),
      .head    (keycode),
      .empty   (empty),
      .full    (full)
   );

   assign key_avail = ~empty;

endmodule
